// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC, squash encoding, FSM state type,
// IF/DEC payload layout, and the jump opcode range used by the BTB and EX.
package fetch_unit_pkg;

  localparam int unsigned XLEN  = 16;
  localparam int unsigned OPC_W = 4;

  localparam logic [XLEN-1:0] RESET_PC  = 16'h0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

  // Jump opcodes occupy a contiguous range so classification is a compare.
  localparam logic [OPC_W-1:0] OP_JUMP   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_JUMPZ  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_JUMPNZ = 4'b1000;
  localparam logic [OPC_W-1:0] OP_JUMPEQ = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JUMPNE = 4'b1010;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_STALL = 2'd3
  } fetch_state_e;

  // IF/DEC pipeline register contents (valid bit kept separately).
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            predicted;
    logic [XLEN-1:0] pred_target;
  } if_payload_t;

  function automatic logic is_jump(input logic [OPC_W-1:0] op);
    return (op >= OP_JUMP) && (op <= OP_JUMPNE);
  endfunction

  // Sequential PC, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage.
// Priority: redirect > taken prediction > sequential increment; otherwise hold.
// Ports:
//   pc_q       current program counter
//   redirect   BTB redirect (squash and refetch from target)
//   advance    current fetch completed and is being captured
//   pred_taken capture is under a taken prediction
//   target     BTB target (redirect or prediction)
//   next_pc_c  combinational next program counter
module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_q,
  input  logic            redirect,
  input  logic            advance,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc_c
);

  always_comb begin
    next_pc_c = pc_q;
    if (redirect) begin
      next_pc_c = target;
    end else if (advance) begin
      next_pc_c = pred_taken ? target : pc_inc(pc_q);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction
// memory over req/ack, presents fetch_pc to the BTB, applies BTB predictions
// and redirects, and holds the IF/DEC register while decode stalls.
// Optional feature macro: FETCH_BTB_PREDICT_EN (taken predictions steer the
// next PC; when undefined btb_prediction is ignored and if_predicted /
// if_pred_target read 0).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   btb_prediction/target    BTB taken prediction and target for fetch_pc
//   btb_nop                  BTB redirect to btb_target, squashes IF/DEC
//   stall                    decode cannot accept if_* this cycle
//   imem_req/addr/ack/rdata  instruction memory handshake
//   fetch_pc                 PC being fetched, to BTB
//   if_*                     IF/DEC pipeline register
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            btb_prediction,
  input  logic [XLEN-1:0] btb_target,
  input  logic            btb_nop,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] fetch_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_predicted,
  output logic [XLEN-1:0] if_pred_target
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q;
  logic            if_valid_q;
  if_payload_t     if_q;

  logic            accept;
  logic            capture;
  logic            enter_drain;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target_in;

`ifdef FETCH_BTB_PREDICT_EN
  assign pred_taken     = btb_prediction;
  assign pred_target_in = btb_target;
`else
  logic unused_btb_prediction;
  assign unused_btb_prediction = btb_prediction;
  assign pred_taken     = 1'b0;
  assign pred_target_in = '0;
`endif

  // Decode can take a new instruction when the register is empty or draining.
  assign accept = !if_valid_q || !stall;

  // Only a completed request issued from S_REQ delivers usable data.
  assign capture = (state_q == S_REQ) && imem_req && imem_ack && !btb_nop;

  // A request already on the bus cannot be withdrawn, so a redirect during
  // a wait must first let the old request complete.
  assign enter_drain = btb_nop && imem_req && !imem_ack;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (btb_nop) begin
      state_d = enter_drain ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_RESET: state_d = S_REQ;
        S_REQ:   if (!accept)  state_d = S_STALL;
        S_DRAIN: if (imem_ack) state_d = S_REQ;
        S_STALL: if (!stall)   state_d = S_REQ;
        default: state_d = S_RESET;
      endcase
    end
  end

  // Memory request outputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      S_REQ: begin
        imem_req = accept;
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: begin
      end
    endcase
  end

  fetch_next_pc u_next_pc (
    .pc_q       (pc_q),
    .redirect   (btb_nop),
    .advance    (capture),
    .pred_taken (pred_taken),
    .target     (btb_target),
    .next_pc_c  (pc_d)
  );

  // Program counter and the address of a request being drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      // Later redirects while draining keep the original bus address.
      if (enter_drain && (state_q == S_REQ)) begin
        drain_addr_q <= pc_q;
      end
    end
  end

  // IF/DEC pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_q       <= '{instr: NOP_INSTR, pc: '0, predicted: 1'b0, pred_target: '0};
    end else begin
      if (btb_nop) begin
        if_valid_q <= 1'b0;
        if_q.instr <= NOP_INSTR;
      end else if (capture) begin
        if_valid_q <= 1'b1;
        if_q       <= '{instr: imem_rdata, pc: pc_q, predicted: pred_taken,
                        pred_target: pred_target_in};
      end else if (if_valid_q && !stall) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign fetch_pc       = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_q.instr;
  assign if_pc          = if_q.pc;
  assign if_predicted   = if_q.predicted;
  assign if_pred_target = if_q.pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a rule-level fetch model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        btb_prediction;
  logic [15:0] btb_target;
  logic        btb_nop;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] fetch_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_predicted;
  logic [15:0] if_pred_target;

`ifdef FETCH_BTB_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_bad = 0;

  // Memory responder: fixed latency (lat_cfg >= 0) or random 0..2 extra cycles.
  int lat_cfg = 0;
  bit mem_busy;
  int mem_cnt;
  int mem_lat;

  // Reference model of the fetch stage
  bit          m_started;
  bit          m_drain;
  bit          m_hold;
  logic [15:0] m_pc;
  logic [15:0] m_old;
  bit          m_v;
  logic [15:0] m_instr;
  logic [15:0] m_ipc;
  bit          m_ipred;
  logic [15:0] m_itgt;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .btb_prediction (btb_prediction),
    .btb_target     (btb_target),
    .btb_nop        (btb_nop),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .fetch_pc       (fetch_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_predicted   (if_predicted),
    .if_pred_target (if_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Expected request: none before the first cycle out of reset, forced while
  // an abandoned request completes, none while parked on a stall, otherwise
  // whenever decode can accept.
  function automatic logic exp_req();
    if (!m_started) return 1'b0;
    if (m_drain)    return 1'b1;
    if (m_hold)     return 1'b0;
    return !m_v || !stall;
  endfunction

  function automatic logic [15:0] exp_addr();
    return m_drain ? m_old : m_pc;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; btb_nop = 1'b0; btb_prediction = 1'b0; btb_target = 16'h0;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    m_started = 0; m_drain = 0; m_hold = 0; m_pc = 16'h0; m_old = 16'h0;
    m_v = 0; m_instr = 16'h0; m_ipc = 16'h0; m_ipred = 0; m_itgt = 16'h0;
    mem_busy = 0; mem_cnt = 0; mem_lat = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Apply this cycle's inputs and the memory response; outputs settle after.
  task automatic drive(input logic s, input logic n, input logic p, input logic [15:0] t);
    logic er;
    logic ack;
    stall = s; btb_nop = n; btb_prediction = p; btb_target = t;
    er  = exp_req();
    ack = 1'b0;
    if (!er) begin
      mem_busy = 0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1; mem_cnt = 0;
        mem_lat = (lat_cfg < 0) ? int'($urandom_range(2, 0)) : lat_cfg;
      end
      ack = (mem_cnt == mem_lat);
    end
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(exp_addr()) : 16'($urandom);
    #1;
  endtask

  // Update the model with this cycle's events, then move to the next cycle.
  task automatic advance();
    logic er;
    logic cap;
    logic tk;
    er  = exp_req();
    cap = 1'b0;
    if (btb_nop) begin
      if (er && !imem_ack) begin
        if (!m_drain) m_old = m_pc;
        m_drain = 1;
      end else begin
        m_drain = 0;
      end
      m_pc = btb_target; m_started = 1; m_hold = 0; m_v = 0; m_instr = 16'h0000;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_drain) begin
      if (imem_ack) m_drain = 0;
    end else if (m_hold) begin
      if (!stall) m_hold = 0;
    end else if (m_v && stall) begin
      m_hold = 1;
    end else if (er && imem_ack) begin
      cap = 1'b1;
      tk  = PRED_EN && btb_prediction;
      m_instr = mem_word(m_pc); m_ipc = m_pc; m_ipred = tk;
      m_itgt  = PRED_EN ? btb_target : 16'h0;
      m_pc    = tk ? btb_target : m_pc + 16'd1;
      m_v     = 1;
    end
    if (!btb_nop && !cap && m_v && !stall) m_v = 0;
    if (imem_ack) mem_busy = 0;
    else if (mem_busy) mem_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (imem_req !== 1'b0)        begin n_bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_chk++; if (imem_addr !== 16'h0000)   begin n_bad++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
    n_chk++; if (fetch_pc !== 16'h0000)    begin n_bad++; $display("FAIL rst_fetch_pc got=%h exp=0000", fetch_pc); end
    n_chk++; if (if_valid !== 1'b0)        begin n_bad++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    n_chk++; if (if_instr !== 16'h0000)    begin n_bad++; $display("FAIL rst_if_instr got=%h exp=0000", if_instr); end
    n_chk++; if (if_pc !== 16'h0000)       begin n_bad++; $display("FAIL rst_if_pc got=%h exp=0000", if_pc); end
    n_chk++; if (if_predicted !== 1'b0)    begin n_bad++; $display("FAIL rst_if_pred got=%b exp=0", if_predicted); end
    n_chk++; if (if_pred_target !== 16'h0) begin n_bad++; $display("FAIL rst_if_tgt got=%h exp=0000", if_pred_target); end
    // Run a few instructions, then reset asynchronously mid-cycle.
    lat_cfg = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      advance();
    end
    rst = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0 || fetch_pc !== 16'h0000)
      begin n_bad++; $display("FAIL async_rst req/pc got=%b/%h exp=0/0000", imem_req, fetch_pc); end
    n_chk++; if (if_valid !== 1'b0 || if_pc !== 16'h0000)
      begin n_bad++; $display("FAIL async_rst valid/if_pc got=%b/%h exp=0/0000", if_valid, if_pc); end
  endtask

  task automatic test_sequential();
    lat_cfg = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      if (c == 0) begin
        n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL seq_first_req c=%0d got=%b exp=0", c, imem_req); end
      end else begin
        n_chk++; if (imem_req !== 1'b1 || fetch_pc !== 16'(c - 1))
          begin n_bad++; $display("FAIL seq_fetch c=%0d got=%b/%h exp=1/%h", c, imem_req, fetch_pc, 16'(c - 1)); end
      end
      n_chk++; if (if_valid !== (c >= 2))
        begin n_bad++; $display("FAIL seq_valid c=%0d got=%b exp=%b", c, if_valid, (c >= 2)); end
      if (c >= 2) begin
        n_chk++; if (if_pc !== 16'(c - 2) || if_instr !== mem_word(16'(c - 2)))
          begin n_bad++; $display("FAIL seq_if c=%0d got=%h/%h exp=%h/%h", c, if_pc, if_instr, 16'(c - 2), mem_word(16'(c - 2))); end
      end
      advance();
    end
  endtask

  task automatic test_predict();
    logic [15:0] e_fpc;
    logic [15:0] e_tgt;
    lat_cfg = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      advance();
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0040);
    n_chk++; if (fetch_pc !== 16'h0005) begin n_bad++; $display("FAIL pred_pc got=%h exp=0005", fetch_pc); end
    advance();
    e_fpc = PRED_EN ? 16'h0040 : 16'h0006;
    e_tgt = PRED_EN ? 16'h0040 : 16'h0000;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    n_chk++; if (fetch_pc !== e_fpc) begin n_bad++; $display("FAIL pred_next_pc got=%h exp=%h", fetch_pc, e_fpc); end
    n_chk++; if (if_pc !== 16'h0005 || if_predicted !== PRED_EN || if_pred_target !== e_tgt)
      begin n_bad++; $display("FAIL pred_if got=%h/%b/%h exp=0005/%b/%h", if_pc, if_predicted, if_pred_target, PRED_EN, e_tgt); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    n_chk++; if (if_pc !== e_fpc || if_predicted !== 1'b0 || if_instr !== mem_word(e_fpc))
      begin n_bad++; $display("FAIL pred_after got=%h/%b/%h exp=%h/0/%h", if_pc, if_predicted, if_instr, e_fpc, mem_word(e_fpc)); end
    advance();
  endtask

  task automatic test_redirect();
    lat_cfg = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      advance();
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0100);
    n_chk++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL redir_pre_valid got=%b exp=1", if_valid); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    n_chk++; if (if_valid !== 1'b0 || if_instr !== 16'h0000)
      begin n_bad++; $display("FAIL redir_squash got=%b/%h exp=0/0000", if_valid, if_instr); end
    n_chk++; if (fetch_pc !== 16'h0100 || imem_req !== 1'b1 || imem_addr !== 16'h0100)
      begin n_bad++; $display("FAIL redir_fetch got=%h/%b/%h exp=0100/1/0100", fetch_pc, imem_req, imem_addr); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== mem_word(16'h0100))
      begin n_bad++; $display("FAIL redir_first got=%b/%h/%h exp=1/0100/%h", if_valid, if_pc, if_instr, mem_word(16'h0100)); end
    advance();
  endtask

  task automatic test_drain();
    lat_cfg = 2;
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    advance();
    drive(1'b0, 1'b1, 1'b0, 16'h0200);
    n_chk++; if (imem_req !== 1'b1 || imem_ack !== 1'b0)
      begin n_bad++; $display("FAIL drain_setup got=%b/%b exp=1/0", imem_req, imem_ack); end
    advance();
    for (int c = 2; c < 8; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      if (c <= 3) begin
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || fetch_pc !== 16'h0200)
          begin n_bad++; $display("FAIL drain_old c=%0d got=%b/%h/%h exp=1/0000/0200", c, imem_req, imem_addr, fetch_pc); end
      end else if (c <= 6) begin
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || if_valid !== 1'b0)
          begin n_bad++; $display("FAIL drain_new c=%0d got=%b/%h/%b exp=1/0200/0", c, imem_req, imem_addr, if_valid); end
      end else begin
        n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'h0200 || if_instr !== mem_word(16'h0200))
          begin n_bad++; $display("FAIL drain_first got=%b/%h/%h exp=1/0200/%h", if_valid, if_pc, if_instr, mem_word(16'h0200)); end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    lat_cfg = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      advance();
    end
    for (int c = 3; c < 11; c++) begin
      drive((c <= 6), 1'b0, 1'b0, 16'h0);
      if (c <= 6) begin
        n_chk++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0001 || fetch_pc !== 16'h0002)
          begin n_bad++; $display("FAIL stall_hold c=%0d got=%b/%b/%h/%h exp=0/1/0001/0002", c, imem_req, if_valid, if_pc, fetch_pc); end
      end else if (c == 7) begin
        n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'h0001)
          begin n_bad++; $display("FAIL stall_release got=%b/%h exp=1/0001", if_valid, if_pc); end
      end else if (c == 8) begin
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || if_valid !== 1'b0)
          begin n_bad++; $display("FAIL stall_resume got=%b/%h/%b exp=1/0002/0", imem_req, imem_addr, if_valid); end
      end else begin
        n_chk++; if (if_valid !== 1'b1 || if_pc !== 16'(c - 7) || if_instr !== mem_word(16'(c - 7)))
          begin n_bad++; $display("FAIL stall_seq c=%0d got=%b/%h exp=1/%h", c, if_valid, if_pc, 16'(c - 7)); end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    lat_cfg = 0;
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    advance();
    drive(1'b0, 1'b1, 1'b0, 16'hFFFF);
    advance();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    n_chk++; if (fetch_pc !== 16'hFFFF || imem_req !== 1'b1)
      begin n_bad++; $display("FAIL wrap_top got=%h/%b exp=ffff/1", fetch_pc, imem_req); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    n_chk++; if (fetch_pc !== 16'h0000 || if_pc !== 16'hFFFF || if_valid !== 1'b1)
      begin n_bad++; $display("FAIL wrap_next got=%h/%h/%b exp=0000/ffff/1", fetch_pc, if_pc, if_valid); end
    advance();
  endtask

  task automatic test_random();
    logic er;
    lat_cfg = -1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(3, 0) == 0), ($urandom_range(15, 0) == 0),
            ($urandom_range(3, 0) == 0), 16'($urandom));
      er = exp_req();
      n_chk++; if (imem_req !== er)
        begin n_bad++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, er); end
      if (er) begin
        n_chk++; if (imem_addr !== exp_addr())
          begin n_bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, exp_addr()); end
      end
      n_chk++; if (fetch_pc !== m_pc)
        begin n_bad++; $display("FAIL rnd_fetch_pc c=%0d got=%h exp=%h", c, fetch_pc, m_pc); end
      n_chk++; if (if_valid !== m_v)
        begin n_bad++; $display("FAIL rnd_if_valid c=%0d got=%b exp=%b", c, if_valid, m_v); end
      n_chk++; if (if_instr !== m_instr || if_pc !== m_ipc)
        begin n_bad++; $display("FAIL rnd_if_data c=%0d got=%h/%h exp=%h/%h", c, if_instr, if_pc, m_instr, m_ipc); end
      n_chk++; if (if_predicted !== m_ipred || if_pred_target !== m_itgt)
        begin n_bad++; $display("FAIL rnd_if_pred c=%0d got=%b/%h exp=%b/%h", c, if_predicted, if_pred_target, m_ipred, m_itgt); end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; btb_nop = 1'b0; btb_prediction = 1'b0; btb_target = 16'h0;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    test_reset();
    test_sequential();
    test_predict();
    test_redirect();
    test_drain();
    test_stall();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the branch target buffer and decode. Owns the program counter, issues word-addressed requests to instruction memory over a req/ack handshake, and presents the fetch PC to the BTB. Applies BTB taken-predictions and BTB redirect bubbles to next-PC selection, and holds the IF/DEC pipeline register under decode stall.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- NOP_INSTR, 16'h0000, encoding injected into if_instr on squash
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, asynchronous, active-high
- btb_prediction  in  1  BTB predicts taken for current fetch_pc
- btb_target  in  16  predicted / redirect target
- btb_nop  in  1  BTB redirect: squash and refetch from btb_target
- stall  in  1  decode cannot accept if_* this cycle
- imem_req  out  1  instruction memory request
- imem_addr  out  16  request address (equals fetch_pc)
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- fetch_pc  out  16  PC being fetched, to BTB
- if_valid  out  1  IF/DEC register holds a live instruction
- if_instr  out  16  fetched instruction
- if_pc  out  16  PC of if_instr
- if_predicted  out  1  instruction was fetched under a taken prediction
- if_pred_target  out  16  predicted target carried to EX for resolve

## Operation
- States: S_RESET, S_REQ, S_DRAIN, S_STALL. Reset enters S_RESET.
- accept = !if_valid || !stall.
- S_RESET: imem_req=0; next cycle -> S_REQ.
- S_REQ: imem_req = accept. If !accept -> S_STALL. On imem_ack: capture if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1, if_predicted<=btb_prediction, if_pred_target<=btb_target; pc_q <= btb_prediction ? btb_target : pc_q+1. No ack with accept: hold pc_q, keep req.
- btb_nop (any state, highest priority): pc_q<=btb_target; if_valid<=0, if_instr<=NOP_INSTR; ack data in that cycle discarded. If in S_REQ with req high and no ack -> S_DRAIN (requests are not abortable); else -> S_REQ.
- S_DRAIN: imem_req=1 at the old address (drain address register; fetch_pc already shows new pc_q); on ack discard data -> S_REQ. Further btb_nop in S_DRAIN overwrites pc_q (latest wins).
- S_STALL: imem_req=0, if_* held; when stall=0 -> S_REQ.
- Decode consumes when if_valid && !stall; if no new capture that edge, if_valid<=0.
- PC arithmetic 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- BTB inputs are treated as belonging to fetch_pc in the cycle imem_ack is high.

## Timing
- Reset values: imem_req 0, imem_addr/fetch_pc RESET_PC, if_valid 0, if_instr NOP_INSTR, if_pc 0, if_predicted 0, if_pred_target 0, state S_RESET.
- First request the cycle after rst deasserts.
- Zero-wait memory (ack same cycle as req): one instruction per cycle, if_* valid the cycle after ack.
- Redirect: btb_nop in cycle N -> fetch_pc=btb_target in N+1; if_valid=0 in N+1; first redirected instruction in if_* at N+2 (zero-wait, not draining).
- imem_req, imem_addr combinational from state/registers; all if_* registered.
- rst mid-transaction: immediate return to reset values; outstanding ack after reset ignored until S_REQ.

## Configuration
- FETCH_BTB_PREDICT_EN defined: taken predictions steer next PC as above.
- Undefined: next PC always pc_q+1 except on btb_nop; if_predicted tied 0, if_pred_target tied 0; btb_prediction ignored.

## Structure
- Shared package: RESET_PC, NOP_INSTR, state typedef, jump opcode constants (JUMP 4'b0110 .. JUMPNE 4'b1010) shared with BTB/EX.
- One sub-module: fetch_next_pc (combinational next-PC mux: redirect > prediction > increment).

## Test plan
- Reset, zero-wait memory ack every cycle -> fetch_pc 0,1,2,3; if_pc trails by one cycle, if_valid=1 from cycle 2.
- btb_prediction=1, btb_target=16'h0040 at fetch_pc 5 -> next fetch_pc 16'h0040, if_predicted=1, if_pred_target=16'h0040 on if_pc 5.
- btb_nop=1, btb_target=16'h0100 while if_valid=1 -> next cycle if_valid=0, if_instr=NOP_INSTR, fetch_pc=16'h0100.
- 3-cycle-latency memory, btb_nop in wait cycle 1 -> imem_req stays at old address until ack, data discarded, then req at btb_target.
- stall=1 for 4 cycles with if_valid=1 -> imem_req=0, if_* stable; stall drops -> fetch resumes at held pc_q, no instruction lost or duplicated.
- pc_q=16'hFFFF fetched without prediction -> next fetch_pc 16'h0000.
